// File: rtl/fifo_pkg.sv
// Shared FIFO constants and pointer type.
// Used by both the write-side and read-side pointer logic.
package fifo_pkg;

  localparam int FIFO_ADDR_W = 4;
  localparam int FIFO_PTR_W  = 5;
  localparam int FIFO_DEPTH  = 16;

  typedef logic [FIFO_PTR_W-1:0] fifo_ptr_t;

endpackage

// File: rtl/fifo_status_calc.sv
// Combinational level/full/empty from a write and a read pointer.
// Ports: wptr, rptr in; level, full, empty out. Shared by both FIFO ends.
import fifo_pkg::*;

module fifo_status_calc #(
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic [ADDR_W:0] wptr,
  input  logic [ADDR_W:0] rptr,
  output logic [ADDR_W:0] level,
  output logic            full,
  output logic            empty
);

  // Modulo subtraction; the extra wrap bit makes 16 distinct from 0.
  assign level = wptr - rptr;

  assign full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                 (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);

  assign empty = (wptr == rptr);

endmodule

// File: rtl/write_pointer_ctrl.sv
// Write pointer, write qualification, almost-full and sticky overflow.
// Ports: clk, rst, wr, rptr, ovf_clr in; wptr, fifo_we, flags, level out.
import fifo_pkg::*;

module write_pointer_ctrl #(
  parameter int ADDR_W   = FIFO_ADDR_W,
  parameter int AF_LEVEL = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr,
  input  logic [ADDR_W:0] rptr,
  input  logic            ovf_clr,
  output logic [ADDR_W:0] wptr,
  output logic            fifo_we,
  output logic            fifo_full_wire,
  output logic            fifo_empty_wire,
  output logic [ADDR_W:0] fifo_level,
  output logic            fifo_almost_full,
  output logic            fifo_overflow
);

  localparam logic [ADDR_W:0] AF_THR = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] ONE    = (ADDR_W+1)'(1);

  fifo_status_calc #(
    .ADDR_W (ADDR_W)
  ) u_status (
    .wptr  (wptr),
    .rptr  (rptr),
    .level (fifo_level),
    .full  (fifo_full_wire),
    .empty (fifo_empty_wire)
  );

  // Full is judged on the current rptr only; a same-cycle pop
  // does not rescue a write issued while full.
  assign fifo_we = wr & ~fifo_full_wire;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr             <= '0;
      fifo_almost_full <= 1'b0;
      fifo_overflow    <= 1'b0;
    end else begin
      if (fifo_we)
        wptr <= wptr + ONE;
      fifo_almost_full <= (fifo_level >= AF_THR);
      // Set beats clear when both happen together.
      if (wr & fifo_full_wire)
        fifo_overflow <= 1'b1;
      else if (ovf_clr)
        fifo_overflow <= 1'b0;
    end
  end

endmodule
